// File: rtl/io_pkg.sv
// Shared types and constants for the IO channel bank: channel map, status word layout,
// and the output-queue entry format.
package io_pkg;

  localparam int IO_NUM_CHAN    = 8;
  localparam int IO_STATUS_CHAN = 7;
  localparam int IO_DATA_W      = 15;
  localparam int IO_CHAN_W      = 3;
  localparam int IO_CNT_W       = 4;

  localparam int IO_ST_PEND_LSB = 0;
  localparam int IO_ST_OVF      = 7;
  localparam int IO_ST_CNT_LSB  = 8;
  localparam int IO_ST_FULL     = 11;

  typedef logic [IO_DATA_W-1:0] io_word_t;
  typedef logic [IO_CHAN_W-1:0] io_chan_t;

  typedef struct packed {
    io_chan_t chan;
    io_word_t data;
  } io_out_entry_t;

  function automatic io_word_t io_status_word(input logic [IO_NUM_CHAN-2:0] pend,
                                              input logic                   ovf,
                                              input logic [2:0]             cnt,
                                              input logic                   full);
    io_word_t w;
    w = '0;
    w[IO_ST_PEND_LSB +: IO_NUM_CHAN-1] = pend;
    w[IO_ST_OVF]                       = ovf;
    w[IO_ST_CNT_LSB +: 3]              = cnt;
    w[IO_ST_FULL]                      = full;
    return w;
  endfunction

endpackage

// File: rtl/io_out_fifo.sv
// Output queue: registered write, head visible the cycle after a push (no bypass).
// Push while full is accepted only alongside a pop; otherwise the caller sees full and drops.
module io_out_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                push,
  input  io_out_entry_t       push_entry,
  output logic                full,
  input  logic                pop,
  output logic                valid,
  output io_out_entry_t       head,
  output logic [IO_CNT_W-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  io_out_entry_t       mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [IO_CNT_W-1:0] cnt;
  logic                do_pop;
  logic                do_push;

  assign valid   = (cnt != '0);
  assign full    = (cnt == IO_CNT_W'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt;
  assign head    = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + IO_CNT_W'(do_push) - IO_CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/io_channel_bank.sv
// Eight-channel IO bank: 7 data input registers with pending flags, a status channel, and an output
// queue fed by core writes (valid/ready, drop+overflow when full). Macro IO_CHANNEL_LOOPBACK_EN mirrors core writes into inputs.
module io_channel_bank
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           IO_write_en,
  input  logic [2:0]     IO_write_sel,
  input  logic [14:0]    IO_write_data,
  input  logic [2:0]     IO_read_sel,
  output logic [14:0]    IO_read_data,
  input  logic           ext_in_valid,
  input  logic [2:0]     ext_in_chan,
  input  logic [14:0]    ext_in_data,
  output logic           ext_out_valid,
  input  logic           ext_out_ready,
  output logic [2:0]     ext_out_chan,
  output logic [14:0]    ext_out_data
);

`ifdef IO_CHANNEL_LOOPBACK_EN
  localparam bit LOOPBACK_EN = 1'b1;
`else
  localparam bit LOOPBACK_EN = 1'b0;
`endif

  localparam int NDATA = IO_NUM_CHAN - 1;

  io_word_t            in_reg [IO_NUM_CHAN];
  logic [NDATA-1:0]    pending;
  logic                overflow;

  logic                wr_data_chan;
  logic                wr_status;
  logic                q_full;
  logic                q_pop;
  logic                q_drop;
  logic [IO_CNT_W-1:0] q_count;
  io_out_entry_t       q_in;
  io_out_entry_t       q_head;

  logic [NDATA-1:0]    ext_hit;
  logic [NDATA-1:0]    lb_hit;
  logic [NDATA-1:0]    pend_set;
  logic [NDATA-1:0]    pend_clr;

  assign wr_data_chan = IO_write_en && (IO_write_sel != IO_CHAN_W'(IO_STATUS_CHAN));
  assign wr_status    = IO_write_en && (IO_write_sel == IO_CHAN_W'(IO_STATUS_CHAN));
  assign q_in         = '{chan: IO_write_sel, data: IO_write_data};
  assign q_pop        = ext_out_valid && ext_out_ready;
  assign q_drop       = wr_data_chan && q_full && !q_pop;

  io_out_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_out_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (wr_data_chan),
    .push_entry (q_in),
    .full       (q_full),
    .pop        (q_pop),
    .valid      (ext_out_valid),
    .head       (q_head),
    .count      (q_count)
  );

  assign ext_out_chan = q_head.chan;
  assign ext_out_data = q_head.data;

  always_comb begin
    ext_hit = '0;
    lb_hit  = '0;
    for (int i = 0; i < NDATA; i++) begin
      ext_hit[i] = ext_in_valid && (ext_in_chan == IO_CHAN_W'(i));
      lb_hit[i]  = LOOPBACK_EN && wr_data_chan && (IO_write_sel == IO_CHAN_W'(i));
    end
    pend_set = ext_hit | lb_hit;
    pend_clr = wr_status ? IO_write_data[NDATA-1:0] : '0;
  end

  // Set beats write-1-to-clear; external input beats loopback on data.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < IO_NUM_CHAN; i++) begin
        in_reg[i] <= '0;
      end
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < NDATA; i++) begin
        if (ext_hit[i]) begin
          in_reg[i] <= ext_in_data;
        end else if (lb_hit[i]) begin
          in_reg[i] <= IO_write_data;
        end
      end
      pending <= (pending & ~pend_clr) | pend_set;
      if (q_drop) begin
        overflow <= 1'b1;
      end else if (wr_status && IO_write_data[IO_ST_OVF]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    if (IO_read_sel == IO_CHAN_W'(IO_STATUS_CHAN)) begin
      IO_read_data = io_status_word(pending, overflow, q_count[2:0],
                                    q_count == IO_CNT_W'(FIFO_DEPTH));
    end else begin
      IO_read_data = in_reg[IO_read_sel];
    end
  end

endmodule

// File: tb/tb_io_channel_bank.sv
// Bench for io_channel_bank: queue-based reference model compared every cycle, plus directed literal checks.
module tb_io_channel_bank;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        IO_write_en = 1'b0;
  logic [2:0]  IO_write_sel = 3'd0;
  logic [14:0] IO_write_data = 15'd0;
  logic [2:0]  IO_read_sel = 3'd0;
  logic [14:0] IO_read_data;
  logic        ext_in_valid = 1'b0;
  logic [2:0]  ext_in_chan = 3'd0;
  logic [14:0] ext_in_data = 15'd0;
  logic        ext_out_valid;
  logic        ext_out_ready = 1'b0;
  logic [2:0]  ext_out_chan;
  logic [14:0] ext_out_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  io_channel_bank #(.FIFO_DEPTH(DEPTH)) dut (
    .clock         (clk),
    .reset_n       (reset_n),
    .IO_write_en   (IO_write_en),
    .IO_write_sel  (IO_write_sel),
    .IO_write_data (IO_write_data),
    .IO_read_sel   (IO_read_sel),
    .IO_read_data  (IO_read_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_chan   (ext_in_chan),
    .ext_in_data   (ext_in_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ext_out_chan  (ext_out_chan),
    .ext_out_data  (ext_out_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: registers, flag vectors and a queue of {chan,data}.
  logic [14:0] mreg [7];
  logic [6:0]  mpend;
  logic        movf;
  logic [17:0] mq [$];
  bit          mlive = 0;
  logic [6:0]  m_set;
  logic [6:0]  m_clr;
  bit          m_pop;
  bit          m_push;

  function automatic logic [14:0] mread(input logic [2:0] s);
    logic [3:0] n;
    n = 4'(mq.size());
    if (s == 3'd7) return {3'b000, (mq.size() == DEPTH), n[2:0], movf, mpend};
    return mreg[s];
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 7; i++) mreg[i] = '0;
      mpend = '0;
      movf  = 1'b0;
      mq.delete();
      mlive = 1;
    end else begin
      m_pop  = (mq.size() != 0) && ext_out_ready;
      m_push = IO_write_en && (IO_write_sel != 3'd7);
      m_set  = '0;
      if (ext_in_valid && ext_in_chan != 3'd7) begin
        mreg[ext_in_chan]  = ext_in_data;
        m_set[ext_in_chan] = 1'b1;
      end
`ifdef IO_CHANNEL_LOOPBACK_EN
      if (m_push) begin
        if (!(ext_in_valid && ext_in_chan == IO_write_sel)) mreg[IO_write_sel] = IO_write_data;
        m_set[IO_write_sel] = 1'b1;
      end
`endif
      m_clr = (IO_write_en && IO_write_sel == 3'd7) ? IO_write_data[6:0] : 7'd0;
      mpend = (mpend & ~m_clr) | m_set;
      if (IO_write_en && IO_write_sel == 3'd7 && IO_write_data[7]) movf = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (mq.size() < DEPTH) mq.push_back({IO_write_sel, IO_write_data});
        else movf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (mlive) begin
      chk("model_valid", ext_out_valid, mq.size() != 0);
      if (mq.size() != 0) chk("model_head", {ext_out_chan, ext_out_data}, mq[0]);
      chk("model_read", IO_read_data, mread(IO_read_sel));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    IO_write_en  = 1'b0;
    ext_in_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] s, input logic [14:0] d);
    IO_write_en   = 1'b1;
    IO_write_sel  = s;
    IO_write_data = d;
  endtask

  task automatic rd(input logic [2:0] s, output logic [14:0] v);
    IO_read_sel = s;
    #1;
    v = IO_read_data;
  endtask

  logic [14:0] v;

  initial begin
    cyc();
    cyc();
    reset_n = 1'b1;
    // Reset state
    chk("rst_valid", ext_out_valid, 1'b0);
    chk("rst_head", {ext_out_chan, ext_out_data}, 18'd0);
    for (int c = 0; c < 8; c++) begin
      rd(3'(c), v);
      chk("rst_read", v, 15'd0);
    end

    // External input on channel 3, plus ignored input on channel 7
    ext_in_valid = 1'b1; ext_in_chan = 3'd3; ext_in_data = 15'o12345;
    cyc();
    rd(3'd3, v); chk("ext_in_ch3", v, 15'o12345);
    rd(3'd7, v); chk("status_ch3_pend", v, 15'o00010);
    ext_in_valid = 1'b1; ext_in_chan = 3'd7; ext_in_data = 15'o777;
    cyc();
    rd(3'd7, v); chk("ext_in_ch7_ignored", v, 15'o00010);

    // Five writes to channel 1 with sink stalled: fifth is dropped
    ext_out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wr(3'd1, 15'(i));
      cyc();
    end
    rd(3'd7, v); chk("full_status", v[11:7], 5'b11001);
    ext_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_order", {ext_out_valid, ext_out_chan, ext_out_data}, {1'b1, 3'd1, 15'(i)});
      cyc();
    end
    #1;
    chk("fifth_never_out", ext_out_valid, 1'b0);
    ext_out_ready = 1'b0;

    // Clear overflow while chan 3 is set and cleared in the same cycle
    ext_in_valid = 1'b1; ext_in_chan = 3'd3; ext_in_data = 15'o777;
    wr(3'd7, 15'o00210);
    cyc();
    rd(3'd7, v);
`ifdef IO_CHANNEL_LOOPBACK_EN
    chk("set_wins_ovf_clr", v, 15'o00012);
`else
    chk("set_wins_ovf_clr", v, 15'o00010);
`endif
    rd(3'd3, v); chk("ch3_reload", v, 15'o777);
    wr(3'd7, 15'o00377);
    cyc();
    rd(3'd7, v); chk("w1c_all", v, 15'd0);

    // Full queue with simultaneous pop and push
    for (int i = 0; i < 4; i++) begin
      wr(3'd4, 15'(10 + i));
      cyc();
    end
    ext_out_ready = 1'b1;
    wr(3'd5, 15'd14);
    cyc();
    ext_out_ready = 1'b0;
    rd(3'd7, v); chk("full_push_pop_count", v[11:7], 5'b11000);
    ext_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("order_after_full_pp", {ext_out_chan, ext_out_data},
          (i < 3) ? {3'd4, 15'(11 + i)} : {3'd5, 15'd14});
      cyc();
    end
    #1;
    chk("empty_after_pp", ext_out_valid, 1'b0);
    ext_out_ready = 1'b0;
    wr(3'd7, 15'o00377);
    cyc();

    // Loopback behaviour on channel 2, and push-to-output latency
    wr(3'd2, 15'o7);
    #1;
    chk("no_bypass", ext_out_valid, 1'b0);
    cyc();
    rd(3'd2, v);
`ifdef IO_CHANNEL_LOOPBACK_EN
    chk("loopback_ch2", v, 15'o7);
`else
    chk("loopback_ch2", v, 15'o0);
`endif
    chk("loopback_out", {ext_out_valid, ext_out_chan, ext_out_data}, {1'b1, 3'd2, 15'o7});

    // Reset with three entries queued and the sink ready
    wr(3'd0, 15'd1); cyc();
    wr(3'd0, 15'd2); cyc();
    rd(3'd7, v); chk("pre_reset_count", v[10:8], 3'd3);
    ext_out_ready = 1'b1;
    reset_n = 1'b0;
    cyc();
    chk("reset_valid", ext_out_valid, 1'b0);
    chk("reset_head", {ext_out_chan, ext_out_data}, 18'd0);
    rd(3'd7, v); chk("reset_status", v, 15'd0);
    rd(3'd3, v); chk("reset_ch3", v, 15'd0);
    reset_n = 1'b1;
    cyc();
    cyc();
    chk("post_reset_valid", ext_out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_channel_bank.md
IO_CHANNEL_BANK -- requirements
Module: io_channel_bank

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning output-queue entries; power of two, 2 to 8.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 IO_write_en  input  1  core write strobe, one write per asserted cycle.
REQ-005 IO_write_sel  input  3  core write channel.
REQ-006 IO_write_data  input  15  core write data.
REQ-007 IO_read_sel  input  3  core read channel.
REQ-008 IO_read_data  output  15  read data for IO_read_sel, combinational, zero latency.
REQ-009 ext_in_valid  input  1  external input strobe.
REQ-010 ext_in_chan  input  3  external input channel.
REQ-011 ext_in_data  input  15  external input data.
REQ-012 ext_out_valid  output  1  output queue head valid.
REQ-013 ext_out_ready  input  1  external sink accepts the head.
REQ-014 ext_out_chan  output  3  channel of the head entry.
REQ-015 ext_out_data  output  15  data of the head entry.

Function
REQ-016 Channels 0-6 shall be data channels; channel 7 shall be the status channel.
REQ-017 Each data channel shall hold one 15-bit input register and one pending flag.
REQ-018 ext_in_valid on channel 0-6 shall load that input register and set its pending flag at the next edge; on channel 7 it shall be ignored.
REQ-019 Reading channel 0-6 shall return its input register; reads shall have no side effects.
REQ-020 Reading channel 7 shall return: [6:0] pending flags; [7] overflow; [10:8] queue count; [11] queue full; [14:12] zero.
REQ-021 A core write to channel 0-6 shall push {chan,data} into the output queue at the next edge.
REQ-022 A core write to channel 7 shall be write-1-to-clear: data[6:0] clear pending flags and data[7] clears overflow; nothing is pushed.
REQ-023 If set and clear hit the same pending flag in one cycle, set shall win.
REQ-024 ext_out_valid shall be high iff the queue count is nonzero; head fields shall be stable while valid and not ready.
REQ-025 A pop shall occur on any edge with ext_out_valid and ext_out_ready both high.
REQ-026 A push when full without a simultaneous pop shall be dropped and shall set overflow.
REQ-027 A push when full with a simultaneous pop shall be accepted, and the count shall stay FIFO_DEPTH.
REQ-028 A push when empty shall appear on ext_out_* one cycle later; there shall be no bypass.
REQ-029 Queue pointers shall wrap modulo FIFO_DEPTH; the count shall range 0..FIFO_DEPTH.

Reset
REQ-030 With reset_n low at an edge: input registers 0, pending 0, overflow 0, queue emptied, ext_out_valid 0, and ext_out_chan/ext_out_data 0.
REQ-031 Reset mid-transfer shall discard all queued entries with no further handshake.
REQ-032 IO_read_data shall follow the reset register values after the reset edge.

Configuration
REQ-033 Macro IO_CHANNEL_LOOPBACK_EN; when defined, a core write to channel 0-6 shall also load that input register and set its pending flag.
REQ-034 Under loopback, ext_in_valid to the same channel in the same cycle shall win.
REQ-035 Under loopback, the queue push shall still occur.
REQ-036 Without the macro, core writes shall never modify input registers or pending flags.

Structure
REQ-037 A shared package io_pkg shall hold IO_NUM_CHAN=8, IO_STATUS_CHAN=7, the status bit positions, io_word_t (15 bits) and the io_out_entry_t struct {chan, data}.
REQ-038 The queue shall be a sub-module io_out_fifo (push, full, pop, valid, count).

Verification
REQ-039 ext_in on chan 3, data 0o12345 -> read chan 3 = 0o12345; read chan 7 = 0o00010.
REQ-040 Five core writes to chan 1 with ready low -> count 4, full 1, overflow 1; the fifth value is never output.
REQ-041 Full queue, ready high, push in the same cycle -> count stays 4 and output order is preserved.
REQ-042 Core write chan 7 data 0o00210 in the same cycle as ext_in chan 3 -> chan 3 pending stays 1 and overflow clears.
REQ-043 Loopback build: core write chan 2 data 0o7 -> read chan 2 = 0o7 next cycle and ext_out shows {2,0o7}; non-loopback build: read chan 2 stays 0.
REQ-044 Reset with 3 entries queued -> ext_out_valid 0, count 0 and status read 0.
